// File: rtl/sampler_pkg.sv
// Shared types and width helpers for the FFT sample sequencer.
package sampler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int chan_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable period divider: tick fires every div_q+1 enabled cycles, first tick div_q+1 cycles after load.
module tick_divider #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;

    // Equality compare against the latched period keeps cnt within 0..div_q.
    assign tick = en && (cnt == div_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            div_q <= div;
            cnt   <= '0;
        end else if (en) begin
            cnt <= (cnt == div_q) ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/sample_sequencer.sv
// Sample strobe sequencer: steps chan 0..NCH-1 within addr 0..N-1 at a programmable period.
module sample_sequencer
    import sampler_pkg::*;
#(
    parameter int N     = 16,
    parameter int NCH   = 2,
    parameter int DIV_W = 16,
    localparam int AW   = addr_w(N),
    localparam int CW   = chan_w(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [DIV_W-1:0] div,
    input  logic             continuous,
    output logic             sample,
    output logic [CW-1:0]    chan,
    output logic [AW-1:0]    addr,
    output logic             last,
    output logic             run,
    output logic             done
);

    state_t        state;
    logic          cont_q;
    logic          load;
    logic          en;
    logic          tick;
    logic          frame_end;
    logic [AW-1:0] addr_nx;
    logic [CW-1:0] chan_nx;
    logic          last_nx;

    assign load = (state == IDLE) && start;
    assign en   = (state == RUN);

    tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .en   (en),
        .div  (div),
        .tick (tick)
    );

    // addr wraps by explicit compare so N need not be a power of two.
    always_comb begin
        addr_nx = addr;
        chan_nx = chan + CW'(1);
        if (chan == CW'(NCH - 1)) begin
            chan_nx = '0;
            addr_nx = (addr == AW'(N - 1)) ? '0 : addr + AW'(1);
        end
        last_nx = (addr_nx == AW'(N - 1)) && (chan_nx == CW'(NCH - 1));
    end

    // A stop seen in the final-strobe cycle still ends this frame.
    assign frame_end = last && (!cont_q || stop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cont_q <= 1'b0;
            sample <= 1'b0;
            last   <= 1'b0;
            run    <= 1'b0;
            done   <= 1'b0;
            addr   <= '0;
            chan   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done   <= 1'b0;
                    sample <= 1'b0;
                    last   <= 1'b0;
                    if (start) begin
                        state  <= RUN;
                        run    <= 1'b1;
                        sample <= 1'b1;
                        cont_q <= continuous && !stop;
                        addr   <= '0;
                        chan   <= '0;
                    end
                end
                RUN: begin
                    if (stop)
                        cont_q <= 1'b0;
                    if (frame_end) begin
                        state  <= IDLE;
                        run    <= 1'b0;
                        done   <= 1'b1;
                        sample <= 1'b0;
                        last   <= 1'b0;
                        addr   <= '0;
                        chan   <= '0;
                    end else begin
                        done   <= 1'b0;
                        sample <= tick;
                        if (tick) begin
                            addr <= addr_nx;
                            chan <= chan_nx;
                            last <= last_nx;
                        end else begin
                            last <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_sequencer.sv
// Randomized bench for sample_sequencer against a schedule model derived from strobe index arithmetic.
module tb_sample_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] div = '0;
    int          sel = 0;

    always #5 clk = ~clk;

    logic st0, st1, st2, sp0, sp1, sp2;
    assign st0 = start && (sel == 0);
    assign st1 = start && (sel == 1);
    assign st2 = start && (sel == 2);
    assign sp0 = stop && (sel == 0);
    assign sp1 = stop && (sel == 1);
    assign sp2 = stop && (sel == 2);

    logic       sample0, last0, run0, done0;
    logic [0:0] chan0;
    logic [1:0] addr0;
    logic       sample1, last1, run1, done1;
    logic [0:0] chan1;
    logic [1:0] addr1;
    logic       sample2, last2, run2, done2;
    logic [1:0] chan2;
    logic [2:0] addr2;

    sample_sequencer #(.N(4), .NCH(2), .DIV_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(st0), .stop(sp0), .div(div), .continuous(continuous),
        .sample(sample0), .chan(chan0), .addr(addr0), .last(last0), .run(run0), .done(done0)
    );
    sample_sequencer #(.N(4), .NCH(1), .DIV_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .stop(sp1), .div(div), .continuous(continuous),
        .sample(sample1), .chan(chan1), .addr(addr1), .last(last1), .run(run1), .done(done1)
    );
    sample_sequencer #(.N(5), .NCH(3), .DIV_W(16)) dut2 (
        .clk(clk), .rst(rst), .start(st2), .stop(sp2), .div(div), .continuous(continuous),
        .sample(sample2), .chan(chan2), .addr(addr2), .last(last2), .run(run2), .done(done2)
    );

    function automatic int pack(input bit r, input bit d, input bit s, input bit l,
                                input int a, input int c);
        return (int'(r) << 12) | (int'(d) << 11) | (int'(s) << 10) | (int'(l) << 9) | (a << 4) | c;
    endfunction

    int obs;
    always_comb begin
        obs = 0;
        case (sel)
            0: obs = pack(run0, done0, sample0, last0, int'(addr0), int'(chan0));
            1: obs = pack(run1, done1, sample1, last1, int'(addr1), int'(chan1));
            default: obs = pack(run2, done2, sample2, last2, int'(addr2), int'(chan2));
        endcase
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %04h want %04h (run,done,sample,last,addr,chan)", tag, got, want);
        end
    endtask

    // Strobe i sits at cycle 1+i*P; the frame ending operation is the first whose final strobe is at or after the stop cycle.
    task automatic run_frame(input int inst, input int n, input int nch, input int div_v,
                             input bit cont, input bit stop_at_start, input int stopj,
                             input int startj, input string tag);
        int p, s, f, jl, i, idx, want;
        bit strobe;
        p = div_v + 1;
        s = n * nch;
        f = 1;
        if (cont && !stop_at_start && stopj > 0)
            while ((1 + (f * s - 1) * p) < stopj && f < 100) f++;
        jl = 1 + (f * s - 1) * p;
        sel = inst;
        @(negedge clk);
        start = 1'b1;
        div = 16'(div_v);
        continuous = cont;
        stop = stop_at_start;
        for (int j = 1; j <= jl + 2; j++) begin
            @(negedge clk);
            if (j <= jl) begin
                i = (j - 1) / p;
                strobe = ((j - 1) % p) == 0;
                idx = i % s;
                want = pack(1'b1, 1'b0, strobe, strobe && (idx == s - 1), idx / nch, idx % nch);
            end else if (j == jl + 1) begin
                want = pack(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
            end else begin
                want = pack(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
            end
            check($sformatf("%s c%0d", tag, j), obs, want);
            start = (j == startj) && (j <= jl);
            if (start) begin
                div = 16'(div_v + 3);
                continuous = ~cont;
            end
            stop = (j == stopj) && (j <= jl);
        end
        start = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        int inst, n, nch, dv, s, p, stj, sj;
        bit cn;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1 check($sformatf("reset dut%0d", k), obs, 0);
        end
        @(negedge clk);
        rst = 1'b0;

        run_frame(0, 4, 2, 2, 1'b0, 1'b0, 0, 0, "oneshot_d2");
        run_frame(1, 4, 1, 0, 1'b0, 1'b0, 0, 0, "nch1_d0");
        run_frame(0, 4, 2, 1, 1'b1, 1'b0, 20, 0, "cont_stop");
        run_frame(0, 4, 2, 2, 1'b0, 1'b0, 0, 5, "start_in_run");
        run_frame(0, 4, 2, 1, 1'b1, 1'b1, 0, 0, "start_stop_idle");
        run_frame(2, 5, 3, 1, 1'b0, 1'b0, 0, 0, "n5_nch3");
        run_frame(2, 5, 3, 0, 1'b1, 1'b0, 22, 0, "n5_cont");

        // Asynchronous abort mid-frame, then a clean restart.
        sel = 0;
        @(negedge clk);
        start = 1'b1;
        div = 16'd2;
        continuous = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("rst_async", obs, 0);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check($sformatf("rst_hold c%0d", j), obs, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst_no_done", obs, 0);
        run_frame(0, 4, 2, 2, 1'b0, 1'b0, 0, 0, "after_rst");

        for (int t = 0; t < 8; t++) begin
            inst = $urandom_range(0, 2);
            n = (inst == 2) ? 5 : 4;
            nch = (inst == 0) ? 2 : (inst == 1) ? 1 : 3;
            dv = $urandom_range(0, 4);
            cn = 1'($urandom_range(0, 1));
            s = n * nch;
            p = dv + 1;
            stj = cn ? $urandom_range(2, 2 * s * p + 2) : (($urandom_range(0, 1) == 1) ? $urandom_range(2, 1 + (s - 1) * p) : 0);
            sj = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 1 + (s - 1) * p) : 0;
            run_frame(inst, n, nch, dv, cn, 1'b0, stj, sj, $sformatf("rnd%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
Name: sample_sequencer

Overview:
- Parametrised successor of the FFT input sampler.
- Generates sample strobes at a runtime-programmable period, stepping a channel index 0..NCH-1 inside each point address 0..N-1.
- Supports one-shot or continuous frames, graceful stop and a frame-complete flag.
- Sits between the ADC/input capture and the FFT input buffer; addr and chan form the buffer write address.

Parameters:
- N, 16: FFT points per frame; N >= 2.
- NCH, 2: channels per point (2 = real/imag interleave); NCH >= 1.
- DIV_W, 16: width of the period register.
- Derived: AW = $clog2(N); CW = max(1, $clog2(NCH)).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  level-sampled; begins a frame when in IDLE.
- stop  in  1  requests end of continuous operation after the current frame.
- div  in  DIV_W  sample period minus one; latched at start.
- continuous  in  1  1 = restart frames back-to-back; latched at start.
- sample  out  1  one-cycle strobe; addr/chan valid with it.
- chan  out  CW  channel index of the current strobe.
- addr  out  AW  point index of the current strobe.
- last  out  1  high with the final strobe of a frame (addr=N-1, chan=NCH-1).
- run  out  1  high while in RUN.
- done  out  1  one-cycle pulse the cycle after the final strobe of a frame that ends operation.

Behaviour:
- Reset: rst asynchronous and active-high; all of sample, last, run, done, addr, chan and the period counter go to 0; state = IDLE.
- Reset mid-frame aborts immediately, with no done pulse.
- States:
  - IDLE: run=0.
  - RUN: run=1.
- IDLE -> RUN on start=1 at edge k:
  - div_q <= div, cont_q <= continuous, counter <= 0.
  - At k+1: run=1, sample=1, addr=0, chan=0.
- Strobe spacing in RUN: next strobe exactly div_q+1 cycles after the previous one.
  - div_q=0 gives a strobe every cycle.
  - Counter counts 0..div_q and wraps.
- Index order per strobe: chan increments; at chan=NCH-1 it wraps to 0 and addr increments.
  - With NCH=1, chan is held at 0.
- addr/chan hold their value between strobes. They update in the same cycle that sample asserts.
- Final strobe (addr=N-1, chan=NCH-1): last=1 in the same cycle.
- After the final strobe:
  - If cont_q=1 and no stop is pending: addr/chan wrap to 0 and the next strobe follows at the normal spacing.
  - Otherwise: next cycle state=IDLE, run=0, done=1 for one cycle, and addr/chan return to 0.
- stop:
  - In RUN, any stop=1 cycle sets stop_pend, which clears cont_q. The current frame completes, then done.
  - stop in IDLE is ignored.
- start while in RUN: ignored; div/continuous are not re-latched.
- start and stop in the same IDLE cycle: start wins; the frame runs one-shot.
- start asserted in the cycle run falls: ignored. A restart needs start in IDLE.
- Frame length: first strobe at k+1, final strobe at k+1+(N*NCH-1)*(div_q+1), run low and done high one cycle later.
- Widths:
  - Counter is DIV_W bits, compared with div_q for equality; no overflow is possible.
  - addr wraps modulo N by explicit compare, not by natural overflow (N need not be a power of two).
- All outputs are registered.

Decomposition:
- Package sampler_pkg: state enum (IDLE, RUN) and the CW/AW width helper functions.
- Sub-module tick_divider (DIV_W): load/enable inputs, outputs a tick every div_q+1 cycles.
- Index counters and FSM stay in sample_sequencer.

Test Plan:
- Reset: assert rst mid-frame with N=4, NCH=2, div=2 -> all outputs 0 asynchronously; no done; start after release restarts at addr=0.
- One-shot, N=4, NCH=2, div=2, start at k:
  - Strobes at k+1, k+4, ..., k+22.
  - (addr,chan) sequence (0,0),(0,1),(1,0),...,(3,1).
  - last at k+22; run=0 and done=1 at k+23.
- div=0, N=4, NCH=1 -> strobes on 4 consecutive cycles k+1..k+4 with addr 0..3; done at k+5.
- Continuous, N=4, NCH=2, div=1:
  - Strobe after (3,1) is (0,0) two cycles later; no done.
  - Pulse stop mid-second-frame -> that frame completes, done one cycle after its last.
- start pulsed during RUN with a different div -> spacing unchanged.
- start and stop in the same IDLE cycle with continuous=1 -> exactly one frame, then done.
- N=5, NCH=3 -> addr wraps 4->0 with 15 strobes per frame.
